// File: rtl/rdma_pkg.sv
// Shared RC transport constants: header field positions, PSN window,
// response opcode/syndromes and the receive-path enums.
package rdma_pkg;

    localparam int unsigned PSN_W = 24;
    localparam logic [PSN_W-1:0] PSN_HALF = 24'h80_0000;

    localparam logic [7:0] OPC_ACK = 8'h11;

    localparam logic [2:0] SYN_ACK     = 3'b000;
    localparam logic [2:0] SYN_NAK_SEQ = 3'b011;

    localparam int unsigned HDR_OPC_MSB = 63;
    localparam int unsigned HDR_OPC_LSB = 56;
    localparam int unsigned HDR_QPN_MSB = 55;
    localparam int unsigned HDR_QPN_LSB = 32;
    localparam int unsigned HDR_PSN_MSB = 31;
    localparam int unsigned HDR_PSN_LSB = 8;
    localparam int unsigned HDR_ACKREQ  = 7;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        PSN_INORDER = 2'd0,
        PSN_AHEAD   = 2'd1,
        PSN_DUP     = 2'd2
    } psn_class_t;

    function automatic logic [63:0] make_resp(input logic [23:0] qpn,
                                              input logic [23:0] psn,
                                              input logic [2:0]  syn);
        return {OPC_ACK, qpn, psn, syn, 5'b0_0000};
    endfunction

endpackage

// File: rtl/rdma_psn_cmp.sv
// Wrap-aware PSN classifier: in-order, ahead (gap) or duplicate relative
// to the expected PSN, using modulo-2^24 distance and a half-window split.
module rdma_psn_cmp
    import rdma_pkg::*;
(
    input  logic [PSN_W-1:0] psn,
    input  logic [PSN_W-1:0] epsn,
    output psn_class_t       cls
);

    logic [PSN_W-1:0] diff;

    // Subtraction truncates to 24 bits, giving the modular distance directly
    always_comb begin
        diff = psn - epsn;
        if (diff == '0)
            cls = PSN_INORDER;
        else if (diff < PSN_HALF)
            cls = PSN_AHEAD;
        else
            cls = PSN_DUP;
    end

endmodule

// File: rtl/rdma_rc_ack_responder.sv
// Responder-side RC ACK engine: classifies inbound request packets against
// ePSN, forwards in-order packets and emits coalesced ACK / sequence NAK
// beats through a single overwrite-on-queue response slot.
// Optional build macro: RDMA_ACK_STATS_EN adds saturating statistic counters.
module rdma_rc_ack_responder
    import rdma_pkg::*;
#(
    parameter logic [23:0] INIT_EPSN = 24'd0,
    parameter int unsigned ACK_COAL  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] req_data,
    input  logic        req_last,
    output logic        del_valid,
    output logic [63:0] del_data,
    output logic        del_last,
    output logic        ack_valid,
    output logic [63:0] ack_data,
    input  logic        ack_ready
`ifdef RDMA_ACK_STATS_EN
    ,
    output logic [15:0] stat_ack_cnt,
    output logic [15:0] stat_nak_cnt,
    output logic [15:0] stat_dup_cnt
`endif
);

    rx_state_t   state, state_nxt;
    logic [23:0] epsn, epsn_nxt;
    logic [7:0]  coal_cnt, coal_nxt;
    logic        nak_armed, armed_nxt;
    logic        pkt_ackreq, ackreq_nxt;
    logic [23:0] pkt_psn, psn_nxt;
    logic [23:0] pkt_qpn, qpn_nxt;
    logic        fwd;
    logic        resp_load;
    logic [63:0] resp_data;
    psn_class_t  cls;

    logic [23:0] hdr_psn;
    logic [23:0] hdr_qpn;

    assign hdr_psn = req_data[HDR_PSN_MSB:HDR_PSN_LSB];
    assign hdr_qpn = req_data[HDR_QPN_MSB:HDR_QPN_LSB];

    rdma_psn_cmp u_psn_cmp (
        .psn  (hdr_psn),
        .epsn (epsn),
        .cls  (cls)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_HDR;
        else
            state <= state_nxt;
    end

    // Next-state, classification and response selection
    always_comb begin
        state_nxt  = state;
        epsn_nxt   = epsn;
        coal_nxt   = coal_cnt;
        armed_nxt  = nak_armed;
        ackreq_nxt = pkt_ackreq;
        psn_nxt    = pkt_psn;
        qpn_nxt    = pkt_qpn;
        fwd        = 1'b0;
        resp_load  = 1'b0;
        resp_data  = '0;
        if (req_valid) begin
            case (state)
                ST_HDR: begin
                    case (cls)
                        PSN_INORDER: begin
                            state_nxt  = ST_PASS;
                            fwd        = 1'b1;
                            epsn_nxt   = epsn + 24'd1;
                            armed_nxt  = 1'b0;
                            coal_nxt   = coal_cnt + 8'd1;
                            ackreq_nxt = req_data[HDR_ACKREQ];
                            psn_nxt    = hdr_psn;
                            qpn_nxt    = hdr_qpn;
                        end
                        PSN_AHEAD: begin
                            state_nxt = ST_DROP;
                            if (!nak_armed) begin
                                resp_load = 1'b1;
                                resp_data = make_resp(hdr_qpn, epsn, SYN_NAK_SEQ);
                                armed_nxt = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt = ST_DROP;
                            resp_load = 1'b1;
                            resp_data = make_resp(hdr_qpn, epsn - 24'd1, SYN_ACK);
                        end
                    endcase
                end
                ST_PASS: fwd = 1'b1;
                default: fwd = 1'b0;
            endcase
            // Uses the *_nxt context so a header-only packet decides on its own fields
            if (req_last) begin
                state_nxt = ST_HDR;
                if (fwd && (ackreq_nxt || coal_nxt == 8'(ACK_COAL))) begin
                    resp_load = 1'b1;
                    resp_data = make_resp(qpn_nxt, psn_nxt, SYN_ACK);
                    coal_nxt  = '0;
                end
            end
        end
    end

    // Sequence context, delivery pipeline stage and pending response slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epsn       <= INIT_EPSN;
            coal_cnt   <= '0;
            nak_armed  <= 1'b0;
            pkt_ackreq <= 1'b0;
            pkt_psn    <= '0;
            pkt_qpn    <= '0;
            del_valid  <= 1'b0;
            del_data   <= '0;
            del_last   <= 1'b0;
            ack_valid  <= 1'b0;
            ack_data   <= '0;
        end else begin
            epsn       <= epsn_nxt;
            coal_cnt   <= coal_nxt;
            nak_armed  <= armed_nxt;
            pkt_ackreq <= ackreq_nxt;
            pkt_psn    <= psn_nxt;
            pkt_qpn    <= qpn_nxt;
            del_valid  <= fwd;
            if (fwd) begin
                del_data <= req_data;
                del_last <= req_last;
            end
            if (resp_load) begin
                ack_valid <= 1'b1;
                ack_data  <= resp_data;
            end else if (ack_valid && ack_ready) begin
                ack_valid <= 1'b0;
            end
        end
    end

`ifdef RDMA_ACK_STATS_EN
    // Saturating counters: handshakes per syndrome, duplicate headers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ack_cnt <= '0;
            stat_nak_cnt <= '0;
            stat_dup_cnt <= '0;
        end else begin
            if (ack_valid && ack_ready && ack_data[7:5] == SYN_ACK && stat_ack_cnt != '1)
                stat_ack_cnt <= stat_ack_cnt + 16'd1;
            if (ack_valid && ack_ready && ack_data[7:5] == SYN_NAK_SEQ && stat_nak_cnt != '1)
                stat_nak_cnt <= stat_nak_cnt + 16'd1;
            if (req_valid && state == ST_HDR && cls == PSN_DUP && stat_dup_cnt != '1)
                stat_dup_cnt <= stat_dup_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rdma_rc_ack_responder.sv
// Self-checking bench for rdma_rc_ack_responder: table-driven scenarios,
// hand-written wrap/reset sequences and randomized traffic against a
// packet-level reference model.
module tb_rdma_rc_ack_responder;

    localparam int unsigned COAL = 4;
    localparam int MOD = 16777216;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] req_data = '0;
    logic        req_last = 1'b0;
    logic        ack_ready = 1'b1;
    logic        del_valid, del_last, ack_valid;
    logic [63:0] del_data, ack_data;

    logic        w_valid = 1'b0;
    logic [63:0] w_data = '0;
    logic        w_last = 1'b0;
    logic        w_del_valid, w_del_last, w_ack_valid;
    logic [63:0] w_del_data, w_ack_data;

`ifdef RDMA_ACK_STATS_EN
    logic [15:0] s_ack, s_nak, s_dup;
    logic [15:0] w_s_ack, w_s_nak, w_s_dup;
`endif

    always #5 clk = ~clk;

    rdma_rc_ack_responder #(.INIT_EPSN(24'd0), .ACK_COAL(COAL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .del_valid(del_valid), .del_data(del_data), .del_last(del_last),
        .ack_valid(ack_valid), .ack_data(ack_data), .ack_ready(ack_ready)
`ifdef RDMA_ACK_STATS_EN
        , .stat_ack_cnt(s_ack), .stat_nak_cnt(s_nak), .stat_dup_cnt(s_dup)
`endif
    );

    rdma_rc_ack_responder #(.INIT_EPSN(24'hFF_FFFF), .ACK_COAL(COAL)) u_wrap (
        .clk(clk), .rst(rst),
        .req_valid(w_valid), .req_data(w_data), .req_last(w_last),
        .del_valid(w_del_valid), .del_data(w_del_data), .del_last(w_del_last),
        .ack_valid(w_ack_valid), .ack_data(w_ack_data), .ack_ready(1'b1)
`ifdef RDMA_ACK_STATS_EN
        , .stat_ack_cnt(w_s_ack), .stat_nak_cnt(w_s_nak), .stat_dup_cnt(w_s_dup)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] hdr(input int qpn, input int psn, input bit ackreq);
        return {8'h04, 24'(qpn), 24'(psn), ackreq, 7'h00};
    endfunction

    function automatic logic [63:0] resp(input int qpn, input int psn, input logic [2:0] syn);
        return {8'h11, 24'(qpn), 24'(psn), syn, 5'h00};
    endfunction

    // ---------------- reference model (packet level) ----------------
    int          m_epsn, m_coal;
    bit          m_armed, m_inpkt, m_pass, m_ackreq;
    int          m_psn, m_qpn;
    bit          m_del_v, m_del_l, m_ack_v;
    logic [63:0] m_del_d, m_ack_d;
    int          m_st_ack, m_st_nak, m_st_dup;

    task automatic model_reset();
        m_epsn = 0; m_coal = 0; m_armed = 0; m_inpkt = 0; m_pass = 0;
        m_ackreq = 0; m_psn = 0; m_qpn = 0;
        m_del_v = 0; m_del_l = 0; m_del_d = '0; m_ack_v = 0; m_ack_d = '0;
        m_st_ack = 0; m_st_nak = 0; m_st_dup = 0;
    endtask

    task automatic model_beat(input bit v, input logic [63:0] d, input bit l, input bit rdy);
        bit          newr;
        logic [63:0] nd;
        int          psn, qpn, diff;
        newr = 0; nd = '0;
        if (m_ack_v && rdy) begin
            if (m_ack_d[7:5] == 3'b000) m_st_ack++;
            if (m_ack_d[7:5] == 3'b011) m_st_nak++;
        end
        m_del_v = 0;
        if (v) begin
            if (!m_inpkt) begin
                psn = int'(d[31:8]);
                qpn = int'(d[55:32]);
                diff = (psn - m_epsn + MOD) % MOD;
                if (diff == 0) begin
                    m_pass = 1; m_epsn = (m_epsn + 1) % MOD; m_armed = 0; m_coal++;
                    m_ackreq = d[7]; m_psn = psn; m_qpn = qpn;
                end else if (diff < MOD / 2) begin
                    m_pass = 0;
                    if (!m_armed) begin
                        newr = 1; nd = resp(qpn, m_epsn, 3'b011); m_armed = 1;
                    end
                end else begin
                    m_pass = 0;
                    newr = 1; nd = resp(qpn, (m_epsn + MOD - 1) % MOD, 3'b000);
                    m_st_dup++;
                end
            end
            if (m_pass) begin
                m_del_v = 1; m_del_d = d; m_del_l = l;
            end
            if (l && m_pass && (m_ackreq || m_coal == int'(COAL))) begin
                newr = 1; nd = resp(m_qpn, m_psn, 3'b000); m_coal = 0;
            end
            m_inpkt = !l;
        end
        if (newr) begin
            m_ack_v = 1; m_ack_d = nd;
        end else if (m_ack_v && rdy) begin
            m_ack_v = 0;
        end
    endtask

    task automatic step(input bit v, input logic [63:0] d, input bit l, input bit rdy);
        req_valid = v; req_data = d; req_last = l; ack_ready = rdy;
        model_beat(v, d, l, rdy);
        @(posedge clk);
        #1;
        chk("del_valid", {63'b0, del_valid}, {63'b0, m_del_v});
        if (m_del_v) begin
            chk("del_data", del_data, m_del_d);
            chk("del_last", {63'b0, del_last}, {63'b0, m_del_l});
        end
        chk("ack_valid", {63'b0, ack_valid}, {63'b0, m_ack_v});
        if (m_ack_v) chk("ack_data", ack_data, m_ack_d);
    endtask

    task automatic do_reset();
        req_valid = 0; req_last = 0; w_valid = 0; w_last = 0;
        rst = 1;
        #2;
        chk("rst del_valid", {63'b0, del_valid}, 64'd0);
        chk("rst del_last", {63'b0, del_last}, 64'd0);
        chk("rst del_data", del_data, 64'd0);
        chk("rst ack_valid", {63'b0, ack_valid}, 64'd0);
        chk("rst ack_data", ack_data, 64'd0);
`ifdef RDMA_ACK_STATS_EN
        chk("rst stats", {16'd0, s_ack, s_nak, s_dup}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rs;
        bit          v;
        logic [63:0] d;
        bit          l;
        bit          rdy;
        bit          cd;
        bit          edv;
        bit          ca;
        bit          eav;
        logic [63:0] ead;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rs, bit v, logic [63:0] d, bit l, bit rdy,
                                bit cd, bit edv, bit ca, bit eav, logic [63:0] ead);
        vec_t r;
        r.rs = rs; r.v = v; r.d = d; r.l = l; r.rdy = rdy;
        r.cd = cd; r.edv = edv; r.ca = ca; r.eav = eav; r.ead = ead;
        return r;
    endfunction

    initial begin
        int left, qpn, psn, r;
        bit ar;
        model_reset();

        // Coalescing: 5 in-order packets, one ACK for PSN 3
        tbl.push_back(mk(1, 0, '0, 0, 1, 0, 0, 0, 0, '0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, hdr(5, i, 0), 1, 1, 1, 1, 1, i == 3,
                             (i == 3) ? resp(5, 3, 3'b000) : 64'd0));
        tbl.push_back(mk(0, 0, '0, 0, 1, 1, 0, 1, 0, '0));
        // Gap: PSN 2 (3 beats) then PSN 3 -> one NAK for PSN 0
        tbl.push_back(mk(1, 0, '0, 0, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, 1, hdr(6, 2, 0), 0, 1, 1, 0, 1, 1, resp(6, 0, 3'b011)));
        tbl.push_back(mk(0, 1, 64'hDEAD_BEEF_0000_0001, 0, 1, 1, 0, 1, 0, '0));
        tbl.push_back(mk(0, 1, 64'hDEAD_BEEF_0000_0002, 1, 1, 1, 0, 1, 0, '0));
        tbl.push_back(mk(0, 1, hdr(6, 3, 0), 1, 1, 1, 0, 1, 0, '0));
        // Duplicate at ePSN=10: PSN 7 -> ACK PSN 9
        tbl.push_back(mk(1, 0, '0, 0, 1, 0, 0, 0, 0, '0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, hdr(7, i, 0), 1, 1, 1, 1, 0, 0, '0));
        tbl.push_back(mk(0, 1, hdr(8, 7, 0), 0, 1, 1, 0, 1, 1, resp(8, 9, 3'b000)));
        tbl.push_back(mk(0, 1, 64'h1234_5678_9ABC_DEF0, 1, 1, 1, 0, 1, 0, '0));
        // Overwrite while stalled: NAK replaced by later ACK
        tbl.push_back(mk(1, 0, '0, 0, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, 1, hdr(9, 1, 0), 1, 0, 1, 0, 1, 1, resp(9, 0, 3'b011)));
        tbl.push_back(mk(0, 1, hdr(9, 0, 1), 1, 0, 1, 1, 1, 1, resp(9, 0, 3'b000)));
        tbl.push_back(mk(0, 0, '0, 0, 0, 1, 0, 1, 1, resp(9, 0, 3'b000)));
        tbl.push_back(mk(0, 0, '0, 0, 0, 1, 0, 1, 1, resp(9, 0, 3'b000)));
        tbl.push_back(mk(0, 0, '0, 0, 1, 1, 0, 1, 0, '0));
        tbl.push_back(mk(0, 0, '0, 0, 1, 1, 0, 1, 0, '0));

        // Wrap instance initial reset values
        #2;
        chk("wrap rst ack_valid", {63'b0, w_ack_valid}, 64'd0);
        chk("wrap rst del_valid", {63'b0, w_del_valid}, 64'd0);

        foreach (tbl[k]) begin
            if (tbl[k].rs) begin
                do_reset();
            end else begin
                step(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].rdy);
                if (tbl[k].cd) chk($sformatf("tbl%0d del_valid", k), {63'b0, del_valid}, {63'b0, tbl[k].edv});
                if (tbl[k].ca) begin
                    chk($sformatf("tbl%0d ack_valid", k), {63'b0, ack_valid}, {63'b0, tbl[k].eav});
                    if (tbl[k].eav) chk($sformatf("tbl%0d ack_data", k), ack_data, tbl[k].ead);
                end
            end
        end

        // PSN wrap on the INIT_EPSN=0xFFFFFF instance
        w_valid = 1; w_data = hdr(2, 24'hFF_FFFF, 1); w_last = 1;
        @(posedge clk); #1;
        chk("wrap del_valid", {63'b0, w_del_valid}, 64'd1);
        chk("wrap del_data", w_del_data, hdr(2, 24'hFF_FFFF, 1));
        chk("wrap ack_valid", {63'b0, w_ack_valid}, 64'd1);
        chk("wrap ack_data", w_ack_data, resp(2, 24'hFF_FFFF, 3'b000));
        w_data = hdr(2, 0, 1);
        @(posedge clk); #1;
        chk("wrap psn0 del_valid", {63'b0, w_del_valid}, 64'd1);
        chk("wrap psn0 ack_valid", {63'b0, w_ack_valid}, 64'd1);
        chk("wrap psn0 ack_data", w_ack_data, resp(2, 0, 3'b000));
        w_valid = 0; w_last = 0;
        @(posedge clk); #1;
        chk("wrap idle ack_valid", {63'b0, w_ack_valid}, 64'd0);

        // Reset mid-packet, next beat parsed as a header
        do_reset();
        step(1, hdr(3, 0, 0), 0, 1);
        step(1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1);
        chk("midpkt del_valid before rst", {63'b0, del_valid}, 64'd1);
        do_reset();
        step(1, hdr(3, 0, 1), 1, 1);
        chk("post-rst hdr del_valid", {63'b0, del_valid}, 64'd1);
        chk("post-rst ack_data", ack_data, resp(3, 0, 3'b000));

        // Randomized traffic against the model
        do_reset();
        left = 0;
        for (int n = 0; n < 1500; n++) begin
            ar = ($urandom % 4) != 0;
            if (left == 0) begin
                if ($urandom % 5 == 0) begin
                    step(0, {$urandom, $urandom}, $urandom % 2, ar);
                end else begin
                    r = $urandom % 12;
                    if (r < 6)       psn = m_epsn;
                    else if (r < 8)  psn = (m_epsn + 1 + int'($urandom % 3)) % MOD;
                    else if (r < 10) psn = (m_epsn + MOD - 1 - int'($urandom % 3)) % MOD;
                    else             psn = int'($urandom % MOD);
                    qpn  = int'($urandom % MOD);
                    left = 1 + int'($urandom % 4);
                    step(1, hdr(qpn, psn, ($urandom % 4) == 0), left == 1, ar);
                    left--;
                end
            end else if ($urandom % 4 == 0) begin
                step(0, {$urandom, $urandom}, 0, ar);
            end else begin
                step(1, {$urandom, $urandom}, left == 1, ar);
                left--;
            end
        end
`ifdef RDMA_ACK_STATS_EN
        chk("stat_ack_cnt", {48'd0, s_ack}, 64'(m_st_ack));
        chk("stat_nak_cnt", {48'd0, s_nak}, 64'(m_st_nak));
        chk("stat_dup_cnt", {48'd0, s_dup}, 64'(m_st_dup));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
